// File: rtl/ddr3_app_pkg.sv
// ddr3_app_pkg: command encodings and command-FIFO entry type for the DDR3 app responder.
// Revision: 1.0
`default_nettype none

package ddr3_app_pkg;

  localparam logic [2:0] CMD_WRITE = 3'b000;
  localparam logic [2:0] CMD_READ  = 3'b001;

  // Word index is carried at a fixed width; the responder uses the low MEM_DEPTH_LOG2 bits.
  localparam int IDX_W = 32;

  typedef struct packed {
    logic [2:0]       cmd;
    logic [IDX_W-1:0] idx;
  } cmd_entry_t;

  function automatic logic cmd_legal(input logic [2:0] cmd);
    return (cmd == CMD_WRITE) || (cmd == CMD_READ);
  endfunction

endpackage

`default_nettype wire

// File: rtl/ddr3_app_responder_if.sv
// ddr3_app_responder_if: DDR3 controller user (app) command, write-data and read-return bus.
// Revision: 1.0
`default_nettype none

interface ddr3_app_responder_if #(
  parameter int ADDR_WIDTH = 30,
  parameter int DATA_WIDTH = 512
);
  logic [ADDR_WIDTH-1:0] app_addr;
  logic [2:0]            app_cmd;
  logic                  app_en;
  logic                  app_rdy;
  logic [DATA_WIDTH-1:0] app_wdf_data;
  logic                  app_wdf_wren;
  logic                  app_wdf_end;
  logic                  app_wdf_rdy;
  logic [DATA_WIDTH-1:0] app_rd_data;
  logic                  app_rd_data_valid;
  logic                  app_rd_data_end;

  modport master (
    output app_addr, app_cmd, app_en, app_wdf_data, app_wdf_wren, app_wdf_end,
    input  app_rdy, app_wdf_rdy, app_rd_data, app_rd_data_valid, app_rd_data_end
  );

  modport slave (
    input  app_addr, app_cmd, app_en, app_wdf_data, app_wdf_wren, app_wdf_end,
    output app_rdy, app_wdf_rdy, app_rd_data, app_rd_data_valid, app_rd_data_end
  );
endinterface

`default_nettype wire

// File: rtl/ddr3_app_sync_fifo.sv
// ddr3_app_sync_fifo: synchronous FIFO, 2**DEPTH_LOG2 entries, show-ahead read port.
// Revision: 1.0
`default_nettype none

module ddr3_app_sync_fifo #(
  parameter int WIDTH      = 8,
  parameter int DEPTH_LOG2 = 2
) (
  input  wire logic             clk,
  input  wire logic             rst,
  input  wire logic             push,
  input  wire logic [WIDTH-1:0] push_data,
  input  wire logic             pop,
  output logic      [WIDTH-1:0] pop_data,
  output logic                  full,
  output logic                  empty
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  logic [WIDTH-1:0]    r_mem [DEPTH];
  logic [DEPTH_LOG2:0] r_wr_ptr;
  logic [DEPTH_LOG2:0] r_rd_ptr;

  // Extra pointer bit distinguishes full from empty when the low bits match.
  assign empty    = (r_wr_ptr == r_rd_ptr);
  assign full     = (r_wr_ptr[DEPTH_LOG2] != r_rd_ptr[DEPTH_LOG2]) &&
                    (r_wr_ptr[DEPTH_LOG2-1:0] == r_rd_ptr[DEPTH_LOG2-1:0]);
  assign pop_data = r_mem[r_rd_ptr[DEPTH_LOG2-1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (push && !full) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (pop && !empty) r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !full) r_mem[r_wr_ptr[DEPTH_LOG2-1:0]] <= push_data;
  end

endmodule

`default_nettype wire

// File: rtl/ddr3_app_responder.sv
// ddr3_app_responder: simulation-side DDR3 app-interface responder (calibration, FIFOs, in-order executor).
// Optional DDR3_APP_RDY_THROTTLE_EN forces app_rdy low one cycle in four. Revision: 1.0
`default_nettype none

module ddr3_app_responder
  import ddr3_app_pkg::*;
#(
  parameter int ADDR_WIDTH      = 30,
  parameter int DATA_WIDTH      = 512,
  parameter int MEM_DEPTH_LOG2  = 12,
  parameter int RD_LATENCY      = 8,
  parameter int CALIB_CYCLES    = 16,
  parameter int FIFO_DEPTH_LOG2 = 2
) (
  input  wire logic             clk,
  input  wire logic             rst,
  output logic                  init_calib_complete,
  ddr3_app_responder_if.slave   app,
  output logic                  proto_err
);

  localparam int CMD_W = $bits(cmd_entry_t);

  logic [31:0] r_calib_cnt;
  logic        r_calib;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_calib_cnt <= 32'(CALIB_CYCLES);
      r_calib     <= 1'b0;
    end else if (r_calib_cnt != 32'd0) begin
      r_calib_cnt <= r_calib_cnt - 32'd1;
    end else begin
      r_calib     <= 1'b1;
    end
  end

  assign init_calib_complete = r_calib;

  logic w_thr_ok;
`ifdef DDR3_APP_RDY_THROTTLE_EN
  logic [1:0] r_thr_cnt;
  always_ff @(posedge clk) begin
    if (rst) r_thr_cnt <= 2'b00;
    else     r_thr_cnt <= r_thr_cnt + 2'b01;
  end
  assign w_thr_ok = (r_thr_cnt != 2'b11);
`else
  assign w_thr_ok = 1'b1;
`endif

  logic                  w_cmd_full, w_cmd_empty, w_cmd_push, w_cmd_pop;
  logic                  w_wdf_full, w_wdf_empty, w_wdf_push, w_wdf_pop;
  cmd_entry_t            w_cmd_in, w_head;
  logic [DATA_WIDTH-1:0] w_wdf_head;

  assign app.app_rdy     = r_calib && !w_cmd_full && w_thr_ok;
  assign app.app_wdf_rdy = r_calib && !w_wdf_full;
  assign w_cmd_push      = app.app_en && app.app_rdy;
  assign w_wdf_push      = app.app_wdf_wren && app.app_wdf_rdy;

  assign w_cmd_in.cmd = app.app_cmd;
  assign w_cmd_in.idx = IDX_W'(app.app_addr[MEM_DEPTH_LOG2+2:3]);

  // Address bits outside the word index are deliberately ignored (byte lane and wrap).
  logic w_unused_addr;
  assign w_unused_addr = ^{app.app_addr[ADDR_WIDTH-1:MEM_DEPTH_LOG2+3], app.app_addr[2:0]};

  ddr3_app_sync_fifo #(
    .WIDTH      (CMD_W),
    .DEPTH_LOG2 (FIFO_DEPTH_LOG2)
  ) u_cmd_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (w_cmd_push),
    .push_data (w_cmd_in),
    .pop       (w_cmd_pop),
    .pop_data  (w_head),
    .full      (w_cmd_full),
    .empty     (w_cmd_empty)
  );

  ddr3_app_sync_fifo #(
    .WIDTH      (DATA_WIDTH),
    .DEPTH_LOG2 (FIFO_DEPTH_LOG2)
  ) u_wdf_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (w_wdf_push),
    .push_data (app.app_wdf_data),
    .pop       (w_wdf_pop),
    .pop_data  (w_wdf_head),
    .full      (w_wdf_full),
    .empty     (w_wdf_empty)
  );

  logic [MEM_DEPTH_LOG2-1:0] w_head_idx;
  logic                      w_unused_idx;
  assign w_head_idx   = w_head.idx[MEM_DEPTH_LOG2-1:0];
  assign w_unused_idx = ^w_head.idx[IDX_W-1:MEM_DEPTH_LOG2];

  logic w_mem_we, w_rd_issue;

  always_comb begin
    w_cmd_pop  = 1'b0;
    w_wdf_pop  = 1'b0;
    w_mem_we   = 1'b0;
    w_rd_issue = 1'b0;
    if (!w_cmd_empty) begin
      case (w_head.cmd)
        CMD_READ: begin
          w_cmd_pop  = 1'b1;
          w_rd_issue = 1'b1;
        end
        CMD_WRITE: begin
          // A write at the head blocks everything behind it until its data is present.
          if (!w_wdf_empty) begin
            w_cmd_pop = 1'b1;
            w_wdf_pop = 1'b1;
            w_mem_we  = 1'b1;
          end
        end
        default: w_cmd_pop = 1'b1;
      endcase
    end
  end

  logic [DATA_WIDTH-1:0] r_mem [1 << MEM_DEPTH_LOG2];

  always_ff @(posedge clk) begin
    if (w_mem_we) r_mem[w_head_idx] <= w_wdf_head;
  end

  logic [RD_LATENCY-1:0] r_pipe_vld;
  logic [DATA_WIDTH-1:0] r_pipe_data [RD_LATENCY];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pipe_vld <= '0;
      for (int i = 0; i < RD_LATENCY; i++) r_pipe_data[i] <= '0;
    end else begin
      r_pipe_vld[0]  <= w_rd_issue;
      r_pipe_data[0] <= w_rd_issue ? r_mem[w_head_idx] : '0;
      for (int i = 1; i < RD_LATENCY; i++) begin
        r_pipe_vld[i]  <= r_pipe_vld[i-1];
        r_pipe_data[i] <= r_pipe_data[i-1];
      end
    end
  end

  assign app.app_rd_data       = r_pipe_data[RD_LATENCY-1];
  assign app.app_rd_data_valid = r_pipe_vld[RD_LATENCY-1];
  assign app.app_rd_data_end   = r_pipe_vld[RD_LATENCY-1];

  always_ff @(posedge clk) begin
    if (rst) begin
      proto_err <= 1'b0;
    end else if ((app.app_en && !r_calib) ||
                 (w_cmd_push && !cmd_legal(app.app_cmd)) ||
                 (app.app_wdf_wren != app.app_wdf_end) ||
                 (app.app_wdf_wren && !r_calib)) begin
      proto_err <= 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_ddr3_app_responder.sv
// tb_ddr3_app_responder: table vectors, directed corner sequences and a random run against a memory model.
// Revision: 1.0
`default_nettype none

module tb_ddr3_app_responder;
  localparam int AW = 30;
  localparam int DW = 512;
  localparam int ML = 12;
  localparam int RL = 8;
  localparam int CC = 16;
  localparam int FL = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic calib, perr;
  always #5 clk = ~clk;

  ddr3_app_responder_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  ddr3_app_responder #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MEM_DEPTH_LOG2(ML),
    .RD_LATENCY(RL), .CALIB_CYCLES(CC), .FIFO_DEPTH_LOG2(FL)
  ) dut (
    .clk                 (clk),
    .rst                 (rst),
    .init_calib_complete (calib),
    .app                 (bus),
    .proto_err           (perr)
  );

  int total = 0;
  int bad   = 0;

  logic [DW-1:0] mm [int];     // model memory, keyed by word index
  logic [DW-1:0] exp_q[$];     // read data expected, in return order
  logic [DW-1:0] planned[$];   // data for write commands, in pairing order

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, req);
    end
  endtask

  function automatic int widx(input logic [AW-1:0] a);
    return (int'(a) / 8) % (1 << ML);
  endfunction

  function automatic logic [DW-1:0] rnd512();
    logic [DW-1:0] d;
    for (int k = 0; k < DW / 32; k++) d[k*32 +: 32] = $urandom;
    return d;
  endfunction

  task automatic accept_cmd(input logic [2:0] cmd, input logic [AW-1:0] addr);
    if (cmd == 3'b000) begin
      if (planned.size() == 0) begin
        total++; bad++;
        $display("FAIL model_pairing: got no data want one beat");
      end else begin
        mm[widx(addr)] = planned.pop_front();
      end
    end else if (cmd == 3'b001) begin
      exp_q.push_back(mm.exists(widx(addr)) ? mm[widx(addr)] : '0);
    end
  endtask

  task automatic idle();
    bus.app_en       = 1'b0;
    bus.app_cmd      = 3'b000;
    bus.app_addr     = '0;
    bus.app_wdf_wren = 1'b0;
    bus.app_wdf_end  = 1'b0;
    bus.app_wdf_data = '0;
  endtask

  task automatic cycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle();
    exp_q.delete();
    planned.delete();
    cycle();
    rst = 1'b0;
  endtask

  task automatic wait_calib();
    int n = 0;
    while (!calib && n < 100) begin cycle(); n++; end
    chk("calib_wait", calib, 1);
  endtask

  // Present a command and/or a write beat until each is accepted (bounded).
  task automatic issue(input bit c_en, input logic [2:0] cmd, input logic [AW-1:0] addr,
                       input bit d_en, input logic [DW-1:0] d);
    bit pc = c_en, pd = d_en, ac, ad;
    int n = 0;
    while ((pc || pd) && n < 50) begin
      bus.app_en = pc; bus.app_cmd = cmd; bus.app_addr = addr;
      bus.app_wdf_wren = pd; bus.app_wdf_end = pd; bus.app_wdf_data = d;
      ac = pc && bus.app_rdy;
      ad = pd && bus.app_wdf_rdy;
      @(posedge clk);
      if (ad) begin planned.push_back(d); pd = 1'b0; end
      if (ac) begin accept_cmd(cmd, addr); pc = 1'b0; end
      @(negedge clk);
      n++;
    end
    idle();
    if (pc || pd) begin
      total++; bad++;
      $display("FAIL issue_timeout: got pending=%0d%0d want accepted", pc, pd);
    end
  endtask

  // Read-return checker: order and data against the model, end tied to valid.
  always @(negedge clk) begin
    if (!rst && (bus.app_rd_data_valid || bus.app_rd_data_end)) begin
      chk("rd_end", bus.app_rd_data_end, bus.app_rd_data_valid);
      if (bus.app_rd_data_valid) begin
        if (exp_q.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_rd_valid: got data %0h want no return", bus.app_rd_data);
        end else begin
          chk("rd_data", bus.app_rd_data, exp_q.pop_front());
        end
      end
    end
  end

  typedef struct {
    string         name;
    bit            post_calib;
    bit            en;
    logic [2:0]    cmd;
    bit            wren;
    bit            wend;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    bit            exp_err;
  } vec_t;

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin : main
    vec_t vt[8];
    logic [DW-1:0] d;
    int n, lat, cyc, lows, last_low;
    bit early, seen, r;

    idle();

    // Reset values and calibration timing
    cycle();
    chk("rst_calib", calib, 0);
    chk("rst_rdy", bus.app_rdy, 0);
    chk("rst_wdf_rdy", bus.app_wdf_rdy, 0);
    chk("rst_valid", bus.app_rd_data_valid, 0);
    chk("rst_end", bus.app_rd_data_end, 0);
    chk("rst_data", bus.app_rd_data, 0);
    chk("rst_perr", perr, 0);
    rst = 1'b0;
    n = 0; early = 1'b0;
    while (!calib && n < 100) begin
      if (bus.app_rdy || bus.app_wdf_rdy) early = 1'b1;
      cycle(); n++;
    end
    chk("calib_cycles", n, CC + 1);
    chk("rdy_before_calib", early, 0);
    chk("rdy_at_calib", bus.app_rdy, 1);
    chk("wdf_rdy_at_calib", bus.app_wdf_rdy, 1);

    // Protocol-error vectors; each starts from reset
    vt[0] = '{"en_precal",     0, 1, 3'b001, 0, 0, 30'h0,   '0,     1};
    vt[1] = '{"wren_precal",   0, 0, 3'b000, 1, 1, 30'h0,   '0,     1};
    vt[2] = '{"idle_precal",   0, 0, 3'b000, 0, 0, 30'h0,   '0,     0};
    vt[3] = '{"legal_write",   1, 1, 3'b000, 1, 1, 30'h200, rnd512(), 0};
    vt[4] = '{"illegal_cmd",   1, 1, 3'b101, 0, 0, 30'h8,   '0,     1};
    vt[5] = '{"wren_no_end",   1, 0, 3'b000, 1, 0, 30'h0,   rnd512(), 1};
    vt[6] = '{"end_no_wren",   1, 0, 3'b000, 0, 1, 30'h0,   '0,     1};
    vt[7] = '{"legal_read",    1, 1, 3'b001, 0, 0, 30'h205, '0,     0};
    foreach (vt[i]) begin
      bit ac, ad;
      do_reset();
      if (vt[i].post_calib) wait_calib();
      bus.app_en = vt[i].en; bus.app_cmd = vt[i].cmd; bus.app_addr = vt[i].addr;
      bus.app_wdf_wren = vt[i].wren; bus.app_wdf_end = vt[i].wend; bus.app_wdf_data = vt[i].data;
      ac = vt[i].en && bus.app_rdy;
      ad = vt[i].wren && bus.app_wdf_rdy;
      @(posedge clk);
      if (ad) planned.push_back(vt[i].data);
      if (ac) accept_cmd(vt[i].cmd, vt[i].addr);
      @(negedge clk);
      idle();
      chk(vt[i].name, perr, vt[i].exp_err);
      repeat (12) cycle();
    end

    do_reset();
    wait_calib();

    // Single write then immediate read of the same word, with latency
    d = {16{32'hA5A5A5A5}};
    issue(1, 3'b000, 30'h40, 1, d);
    issue(1, 3'b001, 30'h40, 0, '0);
    lat = 1;
    while (!bus.app_rd_data_valid && lat < 40) begin cycle(); lat++; end
    chk("rd_latency", lat, RL + 1);
    cycle();
    chk("valid_one_cycle", bus.app_rd_data_valid, 0);

    // Write data ahead of commands fills the write-data FIFO
    for (int i = 0; i < 4; i++) issue(0, 3'b000, '0, 1, rnd512());
    chk("wdf_rdy_full", bus.app_wdf_rdy, 0);
    for (int i = 0; i < 4; i++) issue(1, 3'b000, 30'(i * 8), 0, '0);
    repeat (2) cycle();
    chk("wdf_rdy_drained", bus.app_wdf_rdy, 1);
    for (int i = 0; i < 4; i++) issue(1, 3'b001, 30'(i * 8), 0, '0);

    // Address wrap and ignored byte-lane bits
    issue(1, 3'b000, 30'(((1 << ML) + 5) * 8 + 3), 1, rnd512());
    issue(1, 3'b001, 30'(5 * 8), 0, '0);
    repeat (RL + 6) cycle();
    chk("drain_directed", exp_q.size(), 0);

    // 16 back-to-back reads
    n = 0; cyc = 0; lows = 0; last_low = -1;
    while (n < 16 && cyc < 100) begin
      bus.app_en = 1'b1; bus.app_cmd = 3'b001; bus.app_addr = 30'((n % 4) * 8);
      r = bus.app_rdy;
      if (!r) begin
`ifdef DDR3_APP_RDY_THROTTLE_EN
        if (last_low >= 0) chk("throttle_gap", cyc - last_low, 4);
`endif
        last_low = cyc; lows++;
      end
      @(posedge clk);
      if (r) begin accept_cmd(3'b001, 30'((n % 4) * 8)); n++; end
      @(negedge clk);
      cyc++;
    end
    idle();
`ifdef DDR3_APP_RDY_THROTTLE_EN
    chk("throttle_lows", lows >= 4, 1);
`else
    chk("burst_cycles", cyc, 16);
`endif
    repeat (RL + 6) cycle();
    chk("drain_burst", exp_q.size(), 0);

    // Random mixed traffic against the model
    begin
      localparam int N = 150;
      logic [2:0]    rc[N];
      logic [AW-1:0] ra[N];
      logic [DW-1:0] dl[$];
      int            wl[$];
      int            ci, di, w, p;
      bit            pe, pw, ac, ad;
      for (int i = 0; i < N; i++) begin
        p = $urandom_range(0, 99);
        if (p < 5) begin
          rc[i] = 3'($urandom_range(2, 7));
          ra[i] = 30'($urandom_range(0, 1023));
        end else if (p < 50 || wl.size() == 0) begin
          w = $urandom_range(0, 15);
          rc[i] = 3'b000;
          ra[i] = 30'((w + (1 << ML) * $urandom_range(0, 3)) * 8 + $urandom_range(0, 7));
          wl.push_back(w);
          dl.push_back(rnd512());
        end else begin
          w = wl[$urandom_range(0, wl.size() - 1)];
          rc[i] = 3'b001;
          ra[i] = 30'((w + (1 << ML) * $urandom_range(0, 3)) * 8 + $urandom_range(0, 7));
        end
      end
      foreach (dl[k]) planned.push_back(dl[k]);
      ci = 0; di = 0; cyc = 0;
      while ((ci < N || di < dl.size()) && cyc < 3000) begin
        pe = (ci < N) && ($urandom_range(0, 3) != 0);
        pw = (di < dl.size()) && ($urandom_range(0, 2) != 0);
        idle();
        if (pe) begin bus.app_en = 1'b1; bus.app_cmd = rc[ci]; bus.app_addr = ra[ci]; end
        if (pw) begin bus.app_wdf_wren = 1'b1; bus.app_wdf_end = 1'b1; bus.app_wdf_data = dl[di]; end
        ac = pe && bus.app_rdy;
        ad = pw && bus.app_wdf_rdy;
        @(posedge clk);
        if (ac) begin accept_cmd(rc[ci], ra[ci]); ci++; end
        if (ad) di++;
        @(negedge clk);
        cyc++;
      end
      idle();
      chk("random_all_sent", ci + di, N + dl.size());
      repeat (RL + 10) cycle();
      chk("drain_random", exp_q.size(), 0);
    end

    // Reset with reads in flight clears the pipeline and the sticky error
    do_reset();
    wait_calib();
    bus.app_wdf_wren = 1'b1; bus.app_wdf_end = 1'b0; bus.app_wdf_data = rnd512();
    cycle();
    idle();
    chk("perr_wren_no_end", perr, 1);
    for (int i = 0; i < 3; i++) issue(1, 3'b001, 30'(i * 8), 0, '0);
    rst = 1'b1;
    exp_q.delete();
    planned.delete();
    cycle();
    chk("perr_cleared", perr, 0);
    chk("valid_in_rst", bus.app_rd_data_valid, 0);
    rst = 1'b0;
    seen = 1'b0;
    repeat (RL + 12) begin
      if (bus.app_rd_data_valid) seen = 1'b1;
      cycle();
    end
    chk("no_valid_after_rst", seen, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
